// File: rtl/antirrebote_multicanal_pkg.sv
// antirrebote_multicanal_pkg: board clock and ms-to-cycles helpers shared by timing blocks
package antirrebote_multicanal_pkg;
  localparam int CLK_HZ = 12000000;
  function automatic int ms_a_ciclos(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction
endpackage

// File: rtl/antirrebote_multicanal_canal.sv
// antirrebote_canal: one-button synchroniser, stability debouncer and long-press detector
module antirrebote_canal #(
  parameter int CICLOS_REBOTE = 240000,
  parameter int CICLOS_LARGO  = 12000000,
  parameter int SYNC_ETAPAS   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_clean,
  output logic pulso_press,
  output logic pulso_release,
  output logic largo
);
  localparam int CW = $clog2(CICLOS_REBOTE);
  localparam int LW = CICLOS_LARGO > 0 ? $clog2(CICLOS_LARGO + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_REBOTE - 1);
  localparam logic [LW-1:0] LMAX = LW'(CICLOS_LARGO);
  logic [SYNC_ETAPAS-1:0] sync;
  logic cand;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt;
  logic s;
  assign s = sync[SYNC_ETAPAS-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cand <= 1'b0;
      cnt <= '0;
      lcnt <= '0;
      btn_clean <= 1'b0;
      pulso_press <= 1'b0;
      pulso_release <= 1'b0;
      largo <= 1'b0;
    end else begin
      sync <= {sync[SYNC_ETAPAS-2:0], btn};
      pulso_press <= 1'b0;
      pulso_release <= 1'b0;
      if (s != cand) begin
        cand <= s;
        cnt <= '0;
      end else if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
      else if (cand != btn_clean) begin
        btn_clean <= cand;
        pulso_press <= cand;
        pulso_release <= !cand;
      end
      // lcnt saturates at CICLOS_LARGO so largo fires once per press
      if (!btn_clean) lcnt <= '0;
      else if (lcnt < LMAX) lcnt <= lcnt + LW'(1);
      largo <= (CICLOS_LARGO > 0) && btn_clean && (lcnt == LW'(CICLOS_LARGO - 1));
    end
endmodule

// File: rtl/antirrebote_multicanal.sv
// antirrebote_multicanal: N independent debounced button channels
module antirrebote_multicanal
  import antirrebote_multicanal_pkg::*;
#(
  parameter int N_CANALES     = 4,
  parameter int CICLOS_REBOTE = ms_a_ciclos(20),
  parameter int CICLOS_LARGO  = ms_a_ciclos(1000),
  parameter int SYNC_ETAPAS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CANALES-1:0] btn,
  output logic [N_CANALES-1:0] btn_clean,
  output logic [N_CANALES-1:0] pulso_press,
  output logic [N_CANALES-1:0] pulso_release,
  output logic [N_CANALES-1:0] largo
);
  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    antirrebote_canal #(
      .CICLOS_REBOTE(CICLOS_REBOTE),
      .CICLOS_LARGO (CICLOS_LARGO),
      .SYNC_ETAPAS  (SYNC_ETAPAS)
    ) u_canal (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn[i]),
      .btn_clean    (btn_clean[i]),
      .pulso_press  (pulso_press[i]),
      .pulso_release(pulso_release[i]),
      .largo        (largo[i])
    );
  end
endmodule

// File: tb/tb_antirrebote_multicanal.sv
// tb_antirrebote_multicanal: vector table, corner sequences and random run against a window model
module tb_antirrebote_multicanal;
  localparam int CR = 8;
  localparam int CL = 20;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] btn = '0;
  logic [3:0] clean, press, rel, lrg;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  antirrebote_multicanal #(
    .N_CANALES(4), .CICLOS_REBOTE(CR), .CICLOS_LARGO(CL), .SYNC_ETAPAS(2)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_clean(clean), .pulso_press(press), .pulso_release(rel), .largo(lrg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a channel accepts level v once the last CR+1 synchronised samples all equal v
  logic [3:0] q[$];
  logic [3:0] s_old;
  bit run_val[4];
  int run_len[4] = '{default: 1000};
  int high[4];
  logic [3:0] m_clean = '0, m_press = '0, m_rel = '0, m_largo = '0;
  bit prev, nc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int c = 0; c < 4; c++) begin
        run_val[c] = 0;
        run_len[c] = 1000;
        high[c] = 0;
      end
      m_clean = '0; m_press = '0; m_rel = '0; m_largo = '0;
    end else begin
      q.push_back(btn);
      if (q.size() > 3) void'(q.pop_front());
      s_old = (q.size() == 3) ? q[0] : 4'b0;
      for (int c = 0; c < 4; c++) begin
        if (s_old[c] == run_val[c]) run_len[c]++;
        else begin
          run_val[c] = s_old[c];
          run_len[c] = 1;
        end
        prev = m_clean[c];
        nc = (run_len[c] >= CR + 1) ? run_val[c] : prev;
        m_press[c] = nc && !prev;
        m_rel[c] = !nc && prev;
        m_largo[c] = (high[c] == CL);
        high[c] = nc ? high[c] + 1 : 0;
        m_clean[c] = nc;
      end
    end
  end

  always @(negedge clk)
    if (chk_en) chk("model", {clean, press, rel, lrg}, {m_clean, m_press, m_rel, m_largo});

  typedef struct {
    logic [3:0] b;
    int n;
    logic [3:0] c, p, r;
  } vec_t;
  vec_t tabla[8];
  int timer[4];

  initial begin
    tabla[0] = '{4'b0001, 10, 4'b0000, 4'b0000, 4'b0000};
    tabla[1] = '{4'b0001, 1,  4'b0001, 4'b0001, 4'b0000};
    tabla[2] = '{4'b0001, 1,  4'b0001, 4'b0000, 4'b0000};
    tabla[3] = '{4'b0011, 10, 4'b0001, 4'b0000, 4'b0000};
    tabla[4] = '{4'b0011, 1,  4'b0011, 4'b0010, 4'b0000};
    tabla[5] = '{4'b0010, 11, 4'b0010, 4'b0000, 4'b0001};
    tabla[6] = '{4'b0000, 11, 4'b0000, 4'b0000, 4'b0010};
    tabla[7] = '{4'b0000, 5,  4'b0000, 4'b0000, 4'b0000};
    // reset with random buttons
    for (int k = 0; k < 4; k++) begin
      btn = 4'($urandom);
      tick();
      chk("reset_outputs", {clean, press, rel, lrg}, 0);
    end
    btn = '0;
    rst = 0;
    chk_en = 1;
    tick();
    chk("after_reset_release", {clean, press, rel, lrg}, 0);
    repeat (3) tick();
    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      btn = tabla[i].b;
      repeat (tabla[i].n) tick();
      chk($sformatf("vec%0d_clean", i), clean, tabla[i].c);
      chk($sformatf("vec%0d_press", i), press, tabla[i].p);
      chk($sformatf("vec%0d_release", i), rel, tabla[i].r);
    end
    // clean press ch0 with long press
    btn[0] = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("press0_pulse", press[0], k == 11);
      chk("press0_clean", clean[0], k >= 11);
      chk("press0_largo", lrg[0], k == 31);
    end
    // short release glitch on ch0
    btn[0] = 0;
    repeat (5) tick();
    btn[0] = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("glitch0_release", rel[0], 0);
      chk("glitch0_clean", clean[0], 1);
      chk("glitch0_largo", lrg[0], 0);
    end
    // bouncing ch1
    for (int k = 0; k < 30; k++) begin
      btn[1] = ((k / 3) % 2) == 0;
      tick();
      chk("bounce1_quiet", {clean[1], press[1], rel[1], lrg[1]}, 0);
    end
    btn[1] = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("bounce1_press", press[1], k == 11);
    end
    // release before long press on ch2
    btn[2] = 1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("ch2_press", press[2], k == 11);
    end
    btn[2] = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("ch2_release", rel[2], k == 11);
      chk("ch2_no_largo", lrg[2], 0);
    end
    // simultaneous presses, then reset mid-count
    btn = '0;
    repeat (15) tick();
    btn = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("simul_press", press, (k == 11) ? 4'b1010 : 4'b0000);
    end
    chk("simul_clean", clean, 4'b1010);
    btn[3] = 0;
    repeat (4) tick();
    rst = 1;
    #1;
    chk("mid_reset_outputs", {clean, press, rel, lrg}, 0);
    tick();
    btn = '0;
    tick();
    rst = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("post_mid_reset", {clean, press, rel, lrg}, 0);
    end
    // random run against the model
    for (int c = 0; c < 4; c++) timer[c] = $urandom_range(1, 50);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++)
        if (timer[c] == 0) begin
          btn[c] = ~btn[c];
          timer[c] = $urandom_range(1, 50);
        end else timer[c]--;
      if ($urandom_range(599) == 0) begin
        rst = 1;
        tick();
        rst = 0;
      end
      tick();
    end
    repeat (45) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
